// File: rtl/kgp_seq_pkg.sv
// Shared definitions for the KGPMini multi-cycle sequencer: state and
// opcode-class encodings plus the opcode constants used by the class decoder.
package kgp_seq_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } seq_state_t;

    localparam logic [5:0] OP_ALU_R     = 6'b000000;
    localparam logic [5:0] OP_ALU_I     = 6'b000001;
    localparam logic [5:0] OP_LD        = 6'b001000;
    localparam logic [5:0] OP_ST        = 6'b001001;
    localparam logic [5:0] OP_HLT       = 6'b111111;
    // Branches are any opcode of the form 01xxxx: mask the top two bits, then match.
    localparam logic [5:0] OP_BR_MASK   = 6'b110000;
    localparam logic [5:0] OP_BR_MATCH  = 6'b010000;

    typedef enum logic [2:0] {
        CL_ALU_R = 3'd0,
        CL_ALU_I = 3'd1,
        CL_LD    = 3'd2,
        CL_ST    = 3'd3,
        CL_BR    = 3'd4,
        CL_HLT   = 3'd5,
        CL_ILL   = 3'd6
    } op_class_t;

endpackage

// File: rtl/kgp_opclass_decode.sv
// Combinational opcode-to-class decoder; anything not recognised maps to the
// illegal class.
module kgp_opclass_decode
    import kgp_seq_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    // Map the raw opcode onto its instruction class.
    always_comb begin
        op_class = CL_ILL;
        if ((opcode & OP_BR_MASK) == OP_BR_MATCH) begin
            op_class = CL_BR;
        end else begin
            case (opcode)
                OP_ALU_R: op_class = CL_ALU_R;
                OP_ALU_I: op_class = CL_ALU_I;
                OP_LD:    op_class = CL_LD;
                OP_ST:    op_class = CL_ST;
                OP_HLT:   op_class = CL_HLT;
                default:  op_class = CL_ILL;
            endcase
        end
    end

endmodule

// File: rtl/kgp_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGPMini datapath with
// memory handshakes, sticky halt and retired/cycle counters.
module kgp_multicycle_sequencer
    import kgp_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             alu_en,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    seq_state_t       state_r;
    op_class_t        class_r;
    op_class_t        dec_class_s;
    logic [CNT_W-1:0] retired_r;
    logic [CNT_W-1:0] cycles_r;

    logic imem_req_s, ir_write_s, pc_inc_s, pc_load_s, alu_en_s;
    logic dmem_rd_s, dmem_wr_s, reg_write_s, mem_to_reg_s, halted_s;
    logic illegal_op_s, retire_s;

    kgp_opclass_decode u_opclass_decode (
        .opcode   (opcode),
        .op_class (dec_class_s)
    );

    // Phase sequencing; the class is captured in DECODE and steers later phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
            class_r <= CL_ALU_R;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_r <= S_DECODE;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    class_r <= dec_class_s;
                    case (dec_class_s)
                        CL_HLT:  state_r <= S_HALT;
                        CL_ILL:  state_r <= S_FETCH;
                        default: state_r <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (class_r)
                        CL_ALU_R, CL_ALU_I: state_r <= S_WB;
                        CL_LD, CL_ST:       state_r <= S_MEM;
                        default:            state_r <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (!dmem_ready) begin
                        state_r <= S_MEM;
                    end else if (class_r == CL_LD) begin
                        state_r <= S_WB;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_WB:    state_r <= S_FETCH;
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_FETCH;
            endcase
        end
    end

    // Retired-instruction and non-halted cycle counters, both free-wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_r <= {CNT_W{1'b0}};
            cycles_r  <= {CNT_W{1'b0}};
        end else begin
            if (state_r != S_HALT) begin
                cycles_r <= cycles_r + CNT_W'(1);
            end else begin
                cycles_r <= cycles_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Per-phase enables from state, class register and live handshake inputs.
    always_comb begin
        imem_req_s   = 1'b0;
        ir_write_s   = 1'b0;
        pc_inc_s     = 1'b0;
        pc_load_s    = 1'b0;
        alu_en_s     = 1'b0;
        dmem_rd_s    = 1'b0;
        dmem_wr_s    = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        halted_s     = 1'b0;
        illegal_op_s = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                ir_write_s = imem_ready;
                pc_inc_s   = imem_ready;
            end
            S_DECODE: begin
                illegal_op_s = (dec_class_s == CL_ILL);
            end
            S_EXEC: begin
                alu_en_s  = 1'b1;
                pc_load_s = (class_r == CL_BR) & branch_taken;
                retire_s  = (class_r == CL_BR);
            end
            S_MEM: begin
                dmem_rd_s = (class_r == CL_LD);
                dmem_wr_s = (class_r == CL_ST);
                retire_s  = (class_r == CL_ST) & dmem_ready;
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (class_r == CL_LD);
                retire_s     = 1'b1;
            end
            S_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    // Reset forces every strobe low at once, even though FETCH would raise imem_req.
    assign imem_req   = imem_req_s   & ~reset;
    assign ir_write   = ir_write_s   & ~reset;
    assign pc_inc     = pc_inc_s     & ~reset;
    assign pc_load    = pc_load_s    & ~reset;
    assign alu_en     = alu_en_s     & ~reset;
    assign dmem_rd    = dmem_rd_s    & ~reset;
    assign dmem_wr    = dmem_wr_s    & ~reset;
    assign reg_write  = reg_write_s  & ~reset;
    assign mem_to_reg = mem_to_reg_s & ~reset;
    assign halted     = halted_s     & ~reset;
    assign illegal_op = illegal_op_s & ~reset;
    assign state      = state_r;
    assign retired    = retired_r;
    assign cycles     = cycles_r;

endmodule

// File: tb/tb_kgp_multicycle_sequencer.sv
// Scoreboard bench for kgp_multicycle_sequencer: per-instruction phase lists
// are expanded into per-cycle stimulus with the expected response attached.
module tb_kgp_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        imem_ready, dmem_ready, branch_taken;
    logic        imem_req, ir_write, pc_inc, pc_load, alu_en, dmem_rd, dmem_wr;
    logic        reg_write, mem_to_reg, halted, illegal_op;
    logic [2:0]  state;
    logic [31:0] retired, cycles;

    kgp_multicycle_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
        .ir_write(ir_write), .pc_inc(pc_inc), .pc_load(pc_load), .alu_en(alu_en),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .halted(halted), .illegal_op(illegal_op),
        .state(state), .retired(retired), .cycles(cycles)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] O_IMEM = 11'h400, O_IRW = 11'h200, O_PCI = 11'h100,
                            O_PCL  = 11'h080, O_ALU = 11'h040, O_DRD = 11'h020,
                            O_DWR  = 11'h010, O_REGW = 11'h008, O_M2R = 11'h004,
                            O_HALT = 11'h002, O_ILL = 11'h001;

    typedef struct {
        logic [5:0]  op;
        logic        ir, dr, bt;
        logic [2:0]  st;
        logic [10:0] outs;
        logic [31:0] ret, cyc;
    } ent_t;

    ent_t stim_q[$];
    ent_t exp_q[$];
    ent_t drv_e, mon_e;
    logic [31:0] m_ret, m_cyc;
    int n_add = 0, popped = 0;
    int checks = 0, errors = 0;

    wire [10:0] dut_outs = {imem_req, ir_write, pc_inc, pc_load, alu_en, dmem_rd,
                            dmem_wr, reg_write, mem_to_reg, halted, illegal_op};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd1) || (op == 6'd8) || (op == 6'd9) ||
               (op[5:4] == 2'b01) || (op == 6'd63);
    endfunction

    // One cycle of expected behaviour; counters shown are those before the cycle's edge.
    task automatic add(input logic [2:0] st, input logic [5:0] op, input logic ir,
                       input logic dr, input logic bt, input logic [10:0] outs, input bit retire);
        ent_t e;
        e.op = op; e.ir = ir; e.dr = dr; e.bt = bt;
        e.st = st; e.outs = outs; e.ret = m_ret; e.cyc = m_cyc;
        stim_q.push_back(e);
        n_add++;
        if (st != 3'd5) m_cyc = m_cyc + 32'd1;
        if (retire) m_ret = m_ret + 32'd1;
    endtask

    task automatic gen_instr(input logic [5:0] op, input int iw, input int dw, input logic bt);
        bit is_ld, is_st, is_br, is_hlt;
        logic [10:0] mo;
        is_ld = (op == 6'd8); is_st = (op == 6'd9);
        is_br = (op[5:4] == 2'b01); is_hlt = (op == 6'd63);
        for (int i = 0; i < iw; i++) add(3'd0, rnd6(), 1'b0, rb(), rb(), O_IMEM, 0);
        add(3'd0, rnd6(), 1'b1, rb(), rb(), O_IMEM | O_IRW | O_PCI, 0);
        if (is_hlt) begin
            add(3'd1, op, rb(), rb(), rb(), 11'h000, 0);
            return;
        end
        if (!legal(op)) begin
            add(3'd1, op, rb(), rb(), rb(), O_ILL, 0);
            return;
        end
        add(3'd1, op, rb(), rb(), rb(), 11'h000, 0);
        if (is_br) begin
            add(3'd2, rnd6(), rb(), rb(), bt, O_ALU | (bt ? O_PCL : 11'h000), 1);
            return;
        end
        add(3'd2, rnd6(), rb(), rb(), rb(), O_ALU, 0);
        if (is_ld || is_st) begin
            mo = is_ld ? O_DRD : O_DWR;
            for (int i = 0; i < dw; i++) add(3'd3, rnd6(), rb(), 1'b0, rb(), mo, 0);
            add(3'd3, rnd6(), rb(), 1'b1, rb(), mo, is_st);
            if (is_st) return;
        end
        add(3'd4, rnd6(), rb(), rb(), rb(), O_REGW | (is_ld ? O_M2R : 11'h000), 1);
    endtask

    task automatic gen_random(input int n);
        logic [5:0] op;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 5))
                0: op = 6'd0;
                1: op = 6'd1;
                2: op = 6'd8;
                3: op = 6'd9;
                4: op = {2'b01, 4'($urandom)};
                default: begin
                    op = rnd6();
                    while (legal(op)) op = rnd6();
                end
            endcase
            gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (popped < n_add && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (popped < n_add) begin
            errors++;
            $display("FAIL drain_timeout: popped %0d expected %0d", popped, n_add);
        end
    endtask

    // Driver: issue one stimulus cycle and hand its expectation to the monitor.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stim_q.size() > 0) begin
                drv_e = stim_q.pop_front();
                opcode = drv_e.op; imem_ready = drv_e.ir;
                dmem_ready = drv_e.dr; branch_taken = drv_e.bt;
                exp_q.push_back(drv_e);
            end else begin
                opcode = 6'd8; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
            end
        end
    end

    // Monitor: compare whatever the DUT shows mid-cycle against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                popped++;
                chk("state", 32'(state), 32'(mon_e.st));
                chk("outputs", 32'(dut_outs), 32'(mon_e.outs));
                chk("retired", retired, mon_e.ret);
                chk("cycles", cycles, mon_e.cyc);
            end
        end
    end

    initial begin
        int budget;
        int base;
        reset = 1'b1;
        opcode = 6'd8; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outputs", 32'(dut_outs), 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_cycles", cycles, 32'd0);

        // Directed sequence, random mix, then halt.
        @(posedge clk);
        m_ret = 32'd0; m_cyc = 32'd0;
        gen_instr(6'b000000, 0, 0, 1'b0);
        gen_instr(6'b001000, 0, 3, 1'b0);
        gen_instr(6'b010000, 0, 0, 1'b1);
        gen_instr(6'b010000, 0, 0, 1'b0);
        gen_instr(6'b000111, 0, 0, 1'b0);
        gen_random(40);
        gen_instr(6'b111111, 1, 0, 1'b0);
        for (int i = 0; i < 10; i++) add(3'd5, rnd6(), rb(), rb(), rb(), O_HALT, 0);
        #1 reset = 1'b0;
        #1 chk("first_imem_req", 32'(imem_req), 32'd1);
        wait_drain();
        repeat (3) @(posedge clk);
        #2;
        chk("halt_sticky", 32'(dut_outs), 32'(O_HALT));
        chk("halt_cycles_frozen", cycles, m_cyc);

        // Reset in the middle of a store's memory wait.
        reset = 1'b1;
        @(posedge clk);
        m_ret = 32'd0; m_cyc = 32'd0;
        base = popped;
        gen_instr(6'b001001, 0, 8, 1'b0);
        #1 reset = 1'b0;
        budget = 0;
        while (popped < base + 5 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #2;
        chk("st_mem_wr_before_reset", 32'(dmem_wr), 32'd1);
        reset = 1'b1;
        stim_q.delete();
        exp_q.delete();
        n_add = popped;
        #1;
        chk("st_reset_dmem_wr", 32'(dmem_wr), 32'd0);
        chk("st_reset_outputs", 32'(dut_outs), 32'd0);
        chk("st_reset_state", 32'(state), 32'd0);
        chk("st_reset_retired", retired, 32'd0);
        chk("st_reset_cycles", cycles, 32'd0);

        @(posedge clk);
        m_ret = 32'd0; m_cyc = 32'd0;
        gen_instr(6'b000001, 0, 0, 1'b0);
        gen_random(15);
        #1 reset = 1'b0;
        #1 chk("post_reset_imem_req", 32'(imem_req), 32'd1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
